fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/fifo_wr_arb_rr_pick.sv | 40 ++++
 rtl/fifo_wr_arb.sv | 124 ++++++++++++
 tb/tb_fifo_wr_arb.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types and defaults for the shared-FIFO write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam int c_NREQ_DEFAULT = 4;
    localparam int c_DW_DEFAULT   = 8;

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arb_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; searches upward from i_start
//               with wrap-around and reports the first requester found.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_start,
    output logic [IW-1:0]   o_winner,
    output logic            o_valid
);

    int            w_sum;
    logic [IW-1:0] w_idx;

    // Walk from the far end back toward i_start so the closest hit wins.
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_sum    = 0;
        w_idx    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = int'(i_start) + k;
            w_idx = IW'(w_sum % NREQ);
            if (i_req[w_idx]) begin
                o_winner = w_idx;
                o_valid  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arb.sv
// ============================================================================
// Module      : fifo_wr_arb
// Description : Packet-granular round-robin arbiter feeding one shared FIFO.
//               Optional per-producer packet counters: FIFO_WR_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = c_NREQ_DEFAULT,
    parameter int DW   = c_DW_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         last,
    input  logic [NREQ*DW-1:0]      data,
    output logic [NREQ-1:0]         ready,
    output logic                    fifo_wr,
    output logic [DW-1:0]           fifo_data,
    input  logic                    fifo_full,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]      pkt_cnt
`endif
);

    localparam int IW = $clog2(NREQ);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_gnt_id;
    logic [IW-1:0]   w_gnt_nxt;
    logic [IW-1:0]   r_start;
    logic [IW-1:0]   w_start_nxt;
    logic [IW-1:0]   w_pick_id;
    logic            w_pick_vld;
    logic            w_own;
    logic            w_fire;
    logic [NREQ-1:0] w_ready;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .i_req    (req),
        .i_start  (r_start),
        .o_winner (w_pick_id),
        .o_valid  (w_pick_vld)
    );

    // Outputs are masked by rst so the reset cycle itself shows reset values.
    assign w_own  = (r_state == OWN) && !rst;
    assign w_fire = w_own && req[r_gnt_id] && !fifo_full;

    always_comb begin
        w_ready           = '0;
        w_ready[r_gnt_id] = w_fire;
    end

    assign ready     = w_ready;
    assign fifo_wr   = w_fire;
    assign fifo_data = data[int'(r_gnt_id)*DW +: DW];
    assign busy      = w_own;
    assign gnt_id    = rst ? '0 : r_gnt_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_gnt_id <= '0;
            r_start  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt_id <= w_gnt_nxt;
            r_start  <= w_start_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt_id;
        w_start_nxt = r_start;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = OWN;
                    w_gnt_nxt   = w_pick_id;
                end
            end
            OWN: begin
                if (w_fire && last[r_gnt_id]) begin
                    w_state_nxt = IDLE;
                    w_start_nxt = (r_gnt_id == IW'(NREQ - 1)) ? '0 : r_gnt_id + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef FIFO_WR_ARB_STATS_EN
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
        logic [15:0] r_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_ready[gi] && last[gi] && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end

        assign pkt_cnt[gi*16 +: 16] = r_cnt;
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
// ============================================================================
// Module      : tb_fifo_wr_arb
// Description : Self-checking bench for fifo_wr_arb (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  ready;
    logic        fifo_wr;
    logic [7:0]  fifo_data;
    logic        fifo_full;
    logic [1:0]  gnt_id;
    logic        busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [63:0] pkt_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_wr_arb #(
        .NREQ (4),
        .DW   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .last      (last),
        .data      (data),
        .ready     (ready),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data),
        .fifo_full (fifo_full),
        .gnt_id    (gnt_id),
        .busy      (busy)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .pkt_cnt   (pkt_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; last = '0; data = '0; fifo_full = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'hF; last = 4'hF; data = 32'hDEADBEEF; fifo_full = 1'b0;
        step();
        #2;
        n_checks++;
        if ({busy, fifo_wr, ready, gnt_id} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold: got busy=%b wr=%b ready=%b gnt=%0d, want all 0", busy, fifo_wr, ready, gnt_id);
        end
        step();
        rst = 1'b0; req = '0; last = '0;
        #2;
        n_checks++;
        if (busy !== 1'b0 || gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b gnt=%0d, want 0/0", busy, gnt_id);
        end
        step();
    endtask

    task automatic test_single_word();
        do_reset();
        req = 4'b0001; last = 4'b0001; data = 32'h000000A5;
        #2;
        n_checks++;
        if (busy !== 1'b0 || fifo_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: got busy=%b wr=%b, want 0/0", busy, fifo_wr);
        end
        step();
        #2;
        n_checks++;
        if ({busy, fifo_wr, ready, fifo_data} !== {1'b1, 1'b1, 4'b0001, 8'hA5}) begin
            n_fail++;
            $display("FAIL single_accept: got busy=%b wr=%b ready=%b data=%h, want 1 1 0001 a5", busy, fifo_wr, ready, fifo_data);
        end
        step();
        req = '0; last = '0;
        #2;
        n_checks++;
        if (busy !== 1'b0 || fifo_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL single_back_idle: got busy=%b wr=%b, want 0/0", busy, fifo_wr);
        end
        step();
    endtask

    task automatic test_round_robin();
        int wc[4] = '{0, 0, 0, 0};
        int writes = 0;
        int exp_owner;
        int acc_id;
        logic acc;
        do_reset();
        for (int cyc = 0; cyc < 100 && writes < 12; cyc++) begin
            req = 4'hF;
            for (int i = 0; i < 4; i++) begin
                last[i] = (wc[i] == 2);
                data[i*8 +: 8] = {4'(i), 4'(wc[i])};
            end
            #2;
            acc = fifo_wr;
            acc_id = int'(gnt_id);
            if (fifo_wr === 1'b1) begin
                exp_owner = (writes / 3) % 4;
                n_checks++;
                if (gnt_id !== 2'(exp_owner) || ready !== 4'(1 << exp_owner) ||
                    fifo_data !== {4'(exp_owner), 4'(writes % 3)}) begin
                    n_fail++;
                    $display("FAIL rr_write%0d: got gnt=%0d ready=%b data=%h, want gnt=%0d data=%h",
                             writes, gnt_id, ready, fifo_data, exp_owner, {4'(exp_owner), 4'(writes % 3)});
                end
            end
            step();
            if (acc === 1'b1) begin
                wc[acc_id] = (wc[acc_id] == 2) ? 0 : wc[acc_id] + 1;
                writes++;
            end
        end
        n_checks++;
        if (writes != 12) begin
            n_fail++;
            $display("FAIL rr_write_count: got %0d writes, want 12", writes);
        end
        #2;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_gap_idle: got busy=%b, want 0", busy);
        end
        step();
        #2;
        n_checks++;
        if (busy !== 1'b1 || gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL rr_wrap_owner: got busy=%b gnt=%0d, want 1/0", busy, gnt_id);
        end
        step();
    endtask

    task automatic test_full_stall();
        do_reset();
        req = 4'b0100; last = '0; data[23:16] = 8'h20;
        step();
        #2;
        n_checks++;
        if (fifo_wr !== 1'b1 || gnt_id !== 2'd2 || fifo_data !== 8'h20) begin
            n_fail++;
            $display("FAIL stall_word0: got wr=%b gnt=%0d data=%h, want 1 2 20", fifo_wr, gnt_id, fifo_data);
        end
        step();
        data[23:16] = 8'h21; fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            n_checks++;
            if (ready !== 4'b0000 || fifo_wr !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got ready=%b wr=%b busy=%b, want 0000 0 1", c, ready, fifo_wr, busy);
            end
            step();
        end
        fifo_full = 1'b0;
        #2;
        n_checks++;
        if (fifo_wr !== 1'b1 || fifo_data !== 8'h21 || ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL stall_resume: got wr=%b data=%h ready=%b, want 1 21 0100", fifo_wr, fifo_data, ready);
        end
        step();
        data[23:16] = 8'h22; last = 4'b0100;
        #2;
        n_checks++;
        if (fifo_wr !== 1'b1 || fifo_data !== 8'h22) begin
            n_fail++;
            $display("FAIL stall_next_word: got wr=%b data=%h, want 1 22", fifo_wr, fifo_data);
        end
        step();
        req = '0; last = '0;
        #2;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end: got busy=%b, want 0", busy);
        end
        step();
    endtask

    task automatic test_req_gap();
        do_reset();
        req = 4'b0001; last = 4'b0001; data = 32'h33221100;
        step();
        step();
        req = 4'b0011; last = 4'b0000; data = 32'h00001100;
        step();
        #2;
        n_checks++;
        if (gnt_id !== 2'd1 || fifo_wr !== 1'b1 || fifo_data !== 8'h11) begin
            n_fail++;
            $display("FAIL gap_grant1: got gnt=%0d wr=%b data=%h, want 1 1 11", gnt_id, fifo_wr, fifo_data);
        end
        step();
        req = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #2;
            n_checks++;
            if (gnt_id !== 2'd1 || busy !== 1'b1 || fifo_wr !== 1'b0 || ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL gap_hold%0d: got gnt=%0d busy=%b wr=%b ready=%b, want 1 1 0 0000", c, gnt_id, busy, fifo_wr, ready);
            end
            step();
        end
        req = 4'b0011; last = 4'b0010; data = 32'h00001200;
        #2;
        n_checks++;
        if (gnt_id !== 2'd1 || ready !== 4'b0010 || fifo_data !== 8'h12) begin
            n_fail++;
            $display("FAIL gap_last: got gnt=%0d ready=%b data=%h, want 1 0010 12", gnt_id, ready, fifo_data);
        end
        step();
        req = 4'b0001; last = 4'b0000;
        #2;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_release: got busy=%b, want 0", busy);
        end
        step();
        #2;
        n_checks++;
        if (busy !== 1'b1 || gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL gap_next_owner: got busy=%b gnt=%0d, want 1/0", busy, gnt_id);
        end
        step();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        req = 4'b1000; last = '0; data = 32'h30000000;
        step();
        #2;
        n_checks++;
        if (gnt_id !== 2'd3 || fifo_wr !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_grant3: got gnt=%0d wr=%b, want 3 1", gnt_id, fifo_wr);
        end
        step();
        rst = 1'b1; data = 32'h31000000;
        #2;
        n_checks++;
        if (fifo_wr !== 1'b0 || ready !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_mask: got wr=%b ready=%b busy=%b, want 0 0000 0", fifo_wr, ready, busy);
        end
        step();
        rst = 1'b0; req = 4'b1001;
        #2;
        n_checks++;
        if (busy !== 1'b0 || gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL rstmid_idle: got busy=%b gnt=%0d, want 0/0", busy, gnt_id);
        end
        step();
        #2;
        n_checks++;
        if (busy !== 1'b1 || gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL rstmid_regrant: got busy=%b gnt=%0d, want 1/0", busy, gnt_id);
        end
        step();
    endtask

    // Reference: owner index (-1 = none) and next search origin, advanced per edge.
    task automatic test_random();
        int   owner = -1;
        int   ptr = 0;
        logic exp_wr;
        logic [3:0] exp_ready;
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst       = ($urandom_range(0, 299) == 0);
            req       = 4'($urandom);
            last      = 4'($urandom) & 4'($urandom);
            fifo_full = ($urandom_range(0, 3) == 0);
            data      = $urandom;
            #2;
            if (rst) begin
                exp_wr = 1'b0;
                n_checks++;
                if ({busy, fifo_wr, ready, gnt_id} !== 8'h00) begin
                    n_fail++;
                    $display("FAIL rand_rst cyc%0d: got busy=%b wr=%b ready=%b gnt=%0d", cyc, busy, fifo_wr, ready, gnt_id);
                end
            end else if (owner < 0) begin
                exp_wr = 1'b0;
                n_checks++;
                if (busy !== 1'b0 || fifo_wr !== 1'b0 || ready !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL rand_idle cyc%0d: got busy=%b wr=%b ready=%b, want 0 0 0000", cyc, busy, fifo_wr, ready);
                end
            end else begin
                exp_wr    = req[owner] && !fifo_full;
                exp_ready = exp_wr ? 4'(1 << owner) : 4'b0000;
                n_checks++;
                if (busy !== 1'b1 || gnt_id !== 2'(owner) || fifo_wr !== exp_wr ||
                    ready !== exp_ready || fifo_data !== data[owner*8 +: 8]) begin
                    n_fail++;
                    $display("FAIL rand_own cyc%0d: got busy=%b gnt=%0d wr=%b ready=%b data=%h, want 1 %0d %b %b %h",
                             cyc, busy, gnt_id, fifo_wr, ready, fifo_data, owner, exp_wr, exp_ready, data[owner*8 +: 8]);
                end
            end
            if (rst) begin
                owner = -1;
                ptr   = 0;
            end else if (owner < 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (owner < 0 && req[(ptr + k) % 4]) owner = (ptr + k) % 4;
                end
            end else if (exp_wr && last[owner]) begin
                ptr   = (owner + 1) % 4;
                owner = -1;
            end
            step();
        end
        rst = 1'b0;
    endtask

`ifdef FIFO_WR_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        req = 4'b0001; last = 4'b0001; data = 32'h000000A5;
        for (int c = 0; c < 6; c++) step();
        #2;
        n_checks++;
        if (pkt_cnt[15:0] !== 16'd3) begin
            n_fail++;
            $display("FAIL stats_count3: got %0d, want 3", pkt_cnt[15:0]);
        end
        for (int c = 6; c < 140000; c++) step();
        #2;
        n_checks++;
        if (pkt_cnt[15:0] !== 16'hFFFF || pkt_cnt[63:16] !== 48'd0) begin
            n_fail++;
            $display("FAIL stats_saturate: got %h, want 0000...ffff", pkt_cnt);
        end
        req = '0; last = '0;
        step();
    endtask
`endif

    initial begin
        rst = 1'b1; req = '0; last = '0; data = '0; fifo_full = 1'b0;
        test_reset();
        test_single_word();
        test_round_robin();
        test_full_stall();
        test_req_gap();
        test_reset_mid_packet();
        test_random();
`ifdef FIFO_WR_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
